// File: rtl/rv32_issue_scheduler.sv
// Issue scheduler for the rv32 pipeline.
// Generates fetch/decode/execute stall and flush controls for these cases:
//   - load-use and CSR-read interlocks
//   - FENCE draining against outstanding data-bus transactions
//   - multi-cycle flushes after a trap or mret redirect
// Stall/flush outputs are combinational from registered state plus this cycle's inputs.
module rv32_issue_scheduler #(
  parameter int OUTSTANDING_W  = 2,
  parameter int TRAP_FLUSH_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid_in,
  input  logic [4:0] dec_rs1_in,
  input  logic       dec_rs1_read_in,
  input  logic [4:0] dec_rs2_in,
  input  logic       dec_rs2_read_in,
  input  logic       dec_fence_in,
  input  logic       ex_valid_in,
  input  logic [4:0] ex_rd_in,
  input  logic       ex_rd_write_in,
  input  logic       ex_late_result_in,
  input  logic       bus_req_in,
  input  logic       bus_ack_in,
  input  logic       mispredict_in,
  input  logic       trap_in,
  output logic       fetch_stall_out,
  output logic       fetch_flush_out,
  output logic       decode_stall_out,
  output logic       decode_flush_out,
  output logic       execute_flush_out,
  output logic       busy_out
);

  localparam int CNT_W = (TRAP_FLUSH_CYC > 1) ? $clog2(TRAP_FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0]         TRAP_RELOAD = CNT_W'(TRAP_FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]         CNT_ONE     = 1;
  localparam logic [OUTSTANDING_W-1:0] OUT_ONE     = 1;
  localparam logic [OUTSTANDING_W-1:0] OUT_MAX     = '1;

  typedef enum logic [1:0] {ST_RUN, ST_FENCE_DRAIN, ST_TRAP_FLUSH} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         trap_cnt_q, trap_cnt_d;
  logic [OUTSTANDING_W-1:0] outstanding_q, outstanding_d;

  logic load_use;
  logic drain_done;
  logic fetch_stall, fetch_flush, decode_stall, decode_flush, execute_flush;

  // Outstanding data-bus transaction counter.
  // It saturates at its maximum, and an ack while the count is zero is ignored.
  always_comb begin
    outstanding_d = outstanding_q;
    if (bus_req_in && !bus_ack_in && (outstanding_q != OUT_MAX)) begin
      outstanding_d = outstanding_q + OUT_ONE;
    end else if (bus_ack_in && !bus_req_in && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - OUT_ONE;
    end
  end

  // Decode operand depends on an execute result that cannot be forwarded.
  assign load_use = dec_valid_in & ex_valid_in & ex_rd_write_in & ex_late_result_in &
                    (ex_rd_in != 5'd0) &
                    ((dec_rs1_read_in & (dec_rs1_in == ex_rd_in)) |
                     (dec_rs2_read_in & (dec_rs2_in == ex_rd_in)));

  // Memory side is quiet for a fence.
  // An ack landing this cycle counts as already retired, so the fence
  // is released in the same cycle the last transaction completes.
  assign drain_done = (outstanding_d == '0) & !bus_req_in & !ex_valid_in;

  // Next-state logic and stall/flush decode.
  // Priority: trap > mispredict > fence > load-use.
  always_comb begin
    state_d       = state_q;
    trap_cnt_d    = trap_cnt_q;
    fetch_stall   = 1'b0;
    fetch_flush   = 1'b0;
    decode_stall  = 1'b0;
    decode_flush  = 1'b0;
    execute_flush = 1'b0;
    case (state_q)
      ST_RUN, ST_FENCE_DRAIN: begin
        if (trap_in) begin
          fetch_flush   = 1'b1;
          decode_flush  = 1'b1;
          execute_flush = 1'b1;
          trap_cnt_d    = TRAP_RELOAD;
          // A single-cycle flush is fully covered by this cycle.
          state_d       = (TRAP_FLUSH_CYC > 1) ? ST_TRAP_FLUSH : ST_RUN;
        end else if (mispredict_in) begin
          fetch_flush  = 1'b1;
          decode_flush = 1'b1;
          state_d      = ST_RUN;
        end else if (state_q == ST_FENCE_DRAIN) begin
          if (drain_done) begin
            state_d = ST_RUN;
          end else begin
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
          end
        end else if (dec_valid_in && dec_fence_in && !drain_done) begin
          fetch_stall  = 1'b1;
          decode_stall = 1'b1;
          state_d      = ST_FENCE_DRAIN;
        end else if (load_use) begin
          fetch_stall  = 1'b1;
          decode_stall = 1'b1;
          decode_flush = 1'b1;
        end
      end
      ST_TRAP_FLUSH: begin
        fetch_flush   = 1'b1;
        decode_flush  = 1'b1;
        execute_flush = 1'b1;
        if (trap_in) begin
          trap_cnt_d = TRAP_RELOAD;
        end else if (trap_cnt_q <= CNT_ONE) begin
          trap_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          trap_cnt_d = trap_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d    = ST_RUN;
        trap_cnt_d = '0;
      end
    endcase
  end

  // State, trap counter and outstanding counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      trap_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      trap_cnt_q    <= trap_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Outputs are held quiet while reset is asserted.
  assign fetch_stall_out   = !reset & fetch_stall;
  assign fetch_flush_out   = !reset & fetch_flush;
  assign decode_stall_out  = !reset & decode_stall;
  assign decode_flush_out  = !reset & decode_flush;
  assign execute_flush_out = !reset & execute_flush;
  assign busy_out          = !reset & (state_q != ST_RUN);

endmodule

// File: tb/tb_rv32_issue_scheduler.sv
// Self-checking bench for rv32_issue_scheduler.
// Outputs are compared as a packed word:
//   {fetch_stall, fetch_flush, decode_stall, decode_flush, execute_flush, busy}
module tb_rv32_issue_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid_in;
  logic [4:0] dec_rs1_in;
  logic       dec_rs1_read_in;
  logic [4:0] dec_rs2_in;
  logic       dec_rs2_read_in;
  logic       dec_fence_in;
  logic       ex_valid_in;
  logic [4:0] ex_rd_in;
  logic       ex_rd_write_in;
  logic       ex_late_result_in;
  logic       bus_req_in;
  logic       bus_ack_in;
  logic       mispredict_in;
  logic       trap_in;
  logic       fetch_stall_out;
  logic       fetch_flush_out;
  logic       decode_stall_out;
  logic       decode_flush_out;
  logic       execute_flush_out;
  logic       busy_out;

  int n_total = 0;
  int n_pass  = 0;

  rv32_issue_scheduler #(.OUTSTANDING_W(2), .TRAP_FLUSH_CYC(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .dec_valid_in      (dec_valid_in),
    .dec_rs1_in        (dec_rs1_in),
    .dec_rs1_read_in   (dec_rs1_read_in),
    .dec_rs2_in        (dec_rs2_in),
    .dec_rs2_read_in   (dec_rs2_read_in),
    .dec_fence_in      (dec_fence_in),
    .ex_valid_in       (ex_valid_in),
    .ex_rd_in          (ex_rd_in),
    .ex_rd_write_in    (ex_rd_write_in),
    .ex_late_result_in (ex_late_result_in),
    .bus_req_in        (bus_req_in),
    .bus_ack_in        (bus_ack_in),
    .mispredict_in     (mispredict_in),
    .trap_in           (trap_in),
    .fetch_stall_out   (fetch_stall_out),
    .fetch_flush_out   (fetch_flush_out),
    .decode_stall_out  (decode_stall_out),
    .decode_flush_out  (decode_flush_out),
    .execute_flush_out (execute_flush_out),
    .busy_out          (busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [4:0] rs1;
    logic       r1;
    logic [4:0] rs2;
    logic       r2;
    logic       fence;
    logic       exv;
    logic [4:0] rd;
    logic       wr;
    logic       late;
    logic       misp;
    logic [5:0] exp;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic idle();
    dec_valid_in      = 1'b0;
    dec_rs1_in        = 5'd0;
    dec_rs1_read_in   = 1'b0;
    dec_rs2_in        = 5'd0;
    dec_rs2_read_in   = 1'b0;
    dec_fence_in      = 1'b0;
    ex_valid_in       = 1'b0;
    ex_rd_in          = 5'd0;
    ex_rd_write_in    = 1'b0;
    ex_late_result_in = 1'b0;
    bus_req_in        = 1'b0;
    bus_ack_in        = 1'b0;
    mispredict_in     = 1'b0;
    trap_in           = 1'b0;
  endtask

  // Move to the next cycle, just after the edge, with all inputs idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string nm, input logic [5:0] exp);
    logic [5:0] act;
    @(negedge clk);
    act = {fetch_stall_out, fetch_flush_out, decode_stall_out,
           decode_flush_out, execute_flush_out, busy_out};
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end else begin
      n_pass++;
      $display("check %s: got %b ok", nm, act);
    end
  endtask

  // Fence held in decode for the cycle being set up.
  task automatic fence_in_decode();
    dec_valid_in = 1'b1;
    dec_fence_in = 1'b1;
  endtask

  initial begin
    // Combinational vectors: each is applied in RUN with the bus idle.
    //                dv    rs1    r1    rs2    r2    fence exv   rd     wr    late  misp  exp
    vecs[0]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[1]  = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 6'b101100};
    vecs[2]  = '{1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[3]  = '{1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 6'b101100};
    vecs[4]  = '{1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[5]  = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 6'b000000};
    vecs[6]  = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[7]  = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 6'b000000};
    vecs[8]  = '{1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 6'b000000};
    vecs[9]  = '{1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 6'b010100};
    vecs[10] = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000};

    // Reset, including a trap request while reset is held.
    idle();
    reset = 1'b1;
    chk("reset", 6'b000000);
    tick();
    trap_in = 1'b1;
    chk("reset_with_trap", 6'b000000);
    tick();
    reset = 1'b0;
    chk("post_reset", 6'b000000);

    // Table-driven load-use, mispredict and idle-fence vectors.
    for (int i = 0; i < NVEC; i++) begin
      tick();
      dec_valid_in      = vecs[i].dv;
      dec_rs1_in        = vecs[i].rs1;
      dec_rs1_read_in   = vecs[i].r1;
      dec_rs2_in        = vecs[i].rs2;
      dec_rs2_read_in   = vecs[i].r2;
      dec_fence_in      = vecs[i].fence;
      ex_valid_in       = vecs[i].exv;
      ex_rd_in          = vecs[i].rd;
      ex_rd_write_in    = vecs[i].wr;
      ex_late_result_in = vecs[i].late;
      mispredict_in     = vecs[i].misp;
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Counter: 3 req, 1 ack, then req+ack together -> 2 outstanding.
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_req_in = 1'b1;
    end
    tick();
    bus_ack_in = 1'b1;
    tick();
    bus_req_in = 1'b1;
    bus_ack_in = 1'b1;

    // Fence with 2 outstanding: acks at cycles 3 and 5 -> stalls over cycles 0..4.
    for (int c = 0; c <= 6; c++) begin
      tick();
      if (c <= 5) fence_in_decode();
      if (c == 3 || c == 5) bus_ack_in = 1'b1;
      case (c)
        0:       chk($sformatf("fence2_c%0d", c), 6'b101000);
        1, 2, 3, 4: chk($sformatf("fence2_c%0d", c), 6'b101001);
        5:       chk($sformatf("fence2_c%0d", c), 6'b000001);
        default: chk($sformatf("fence2_c%0d", c), 6'b000000);
      endcase
    end

    // Saturation: 4 req -> holds at 3, so three acks are needed to drain.
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_req_in = 1'b1;
    end
    for (int c = 0; c <= 4; c++) begin
      tick();
      if (c <= 3) fence_in_decode();
      if (c >= 1 && c <= 3) bus_ack_in = 1'b1;
      case (c)
        0:       chk($sformatf("fence_sat_c%0d", c), 6'b101000);
        1, 2:    chk($sformatf("fence_sat_c%0d", c), 6'b101001);
        3:       chk($sformatf("fence_sat_c%0d", c), 6'b000001);
        default: chk($sformatf("fence_sat_c%0d", c), 6'b000000);
      endcase
    end

    // Underflow: ack at 0 is ignored, so one req leaves exactly 1 outstanding.
    tick();
    bus_ack_in = 1'b1;
    tick();
    bus_req_in = 1'b1;
    tick();
    fence_in_decode();
    chk("underflow_fence", 6'b101000);
    tick();
    fence_in_decode();
    bus_ack_in = 1'b1;
    chk("underflow_drain", 6'b000001);
    tick();
    chk("underflow_run", 6'b000000);

    // Fence waiting only on execute.
    tick();
    fence_in_decode();
    ex_valid_in = 1'b1;
    chk("fence_exv", 6'b101000);
    tick();
    fence_in_decode();
    chk("fence_exv_done", 6'b000001);

    // Trap during FENCE_DRAIN: flushes for exactly 2 cycles, then RUN.
    tick();
    bus_req_in = 1'b1;
    tick();
    fence_in_decode();
    chk("trapdrain_fence", 6'b101000);
    tick();
    fence_in_decode();
    trap_in = 1'b1;
    chk("trapdrain_flush0", 6'b010111);
    tick();
    chk("trapdrain_flush1", 6'b010111);
    tick();
    chk("trapdrain_run", 6'b000000);
    tick();
    fence_in_decode();
    chk("trapdrain_pending", 6'b101000);
    tick();
    fence_in_decode();
    bus_ack_in = 1'b1;
    chk("trapdrain_ack", 6'b000001);

    // Mispredict during FENCE_DRAIN returns to RUN with fetch/decode flush.
    tick();
    bus_req_in = 1'b1;
    tick();
    fence_in_decode();
    chk("mispdrain_fence", 6'b101000);
    tick();
    fence_in_decode();
    mispredict_in = 1'b1;
    chk("mispdrain_flush", 6'b010101);
    tick();
    bus_ack_in = 1'b1;
    chk("mispdrain_run", 6'b000000);

    // Trap and mispredict together: trap path wins.
    tick();
    trap_in       = 1'b1;
    mispredict_in = 1'b1;
    chk("trap_misp_c0", 6'b010110);
    tick();
    chk("trap_misp_c1", 6'b010111);
    tick();
    chk("trap_misp_c2", 6'b000000);

    // A trap inside TRAP_FLUSH reloads the counter.
    tick();
    trap_in = 1'b1;
    chk("reload_c0", 6'b010110);
    tick();
    trap_in = 1'b1;
    chk("reload_c1", 6'b010111);
    tick();
    chk("reload_c2", 6'b010111);
    tick();
    chk("reload_c3", 6'b000000);

    // Reset while in TRAP_FLUSH with trap_cnt=1.
    tick();
    trap_in = 1'b1;
    chk("rst_trap_c0", 6'b010110);
    tick();
    reset = 1'b1;
    chk("rst_trap_in_reset", 6'b000000);
    tick();
    reset = 1'b0;
    chk("rst_trap_after", 6'b000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
